// File: rtl/flash_ctrl_pkg.sv
// ============================================================================
// Module   : flash_ctrl_pkg
// Brief    : Shared FSM states, command encodings and flash command sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package flash_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    STROBE    = 3'd2,
    HOLD      = 3'd3,
    NEXT      = 3'd4,
    WAIT_DONE = 3'd5,
    RESP      = 3'd6
  } fsm_state_e;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_PROG  = 2'd1,
    OP_ERASE = 2'd2
  } op_e;

  localparam logic [21:0] UNLOCK_ADDR_1 = 22'h000555;
  localparam logic [21:0] UNLOCK_ADDR_2 = 22'h0002AA;
  localparam logic [15:0] CODE_AA       = 16'h00AA;
  localparam logic [15:0] CODE_55       = 16'h0055;
  localparam logic [15:0] CODE_A0       = 16'h00A0;
  localparam logic [15:0] CODE_80       = 16'h0080;
  localparam logic [15:0] CODE_30       = 16'h0030;

  function automatic logic [2:0] seq_len(input op_e op);
    case (op)
      OP_PROG:  return 3'd4;
      OP_ERASE: return 3'd6;
      default:  return 3'd1;
    endcase
  endfunction

  // The final bus cycle of every sequence targets the requester's own address.
  function automatic logic [21:0] seq_addr(input op_e op, input logic [2:0] step,
                                           input logic [21:0] addr);
    if (op == OP_READ || step == seq_len(op) - 3'd1) return addr;
    if (step == 3'd1 || step == 3'd4) return UNLOCK_ADDR_2;
    return UNLOCK_ADDR_1;
  endfunction

  function automatic logic [15:0] seq_data(input op_e op, input logic [2:0] step,
                                           input logic [15:0] wdata);
    if (op == OP_PROG) begin
      case (step)
        3'd0:    return CODE_AA;
        3'd1:    return CODE_55;
        3'd2:    return CODE_A0;
        default: return wdata;
      endcase
    end else if (op == OP_ERASE) begin
      case (step)
        3'd0, 3'd3: return CODE_AA;
        3'd1, 3'd4: return CODE_55;
        3'd2:       return CODE_80;
        default:    return CODE_30;
      endcase
    end
    return wdata;
  endfunction

endpackage

`default_nettype wire

// File: rtl/flash_bus_cycle.sv
// ============================================================================
// Module   : flash_bus_cycle
// Brief    : One SETUP/STROBE/HOLD flash bus cycle per start pulse; done pulses in HOLD.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flash_bus_cycle
  import flash_ctrl_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        write_i,
  input  logic [21:0] addr_i,
  input  logic [15:0] data_i,
  input  logic [15:0] dq_i,
  output logic        done_o,
  output logic [15:0] rdata_o,
  output logic        ce_n_o,
  output logic        oe_n_o,
  output logic        we_n_o,
  output logic [21:0] addr_o,
  output logic [15:0] dq_o,
  output logic        dq_oe_o
);

  localparam logic [7:0] LAST_STROBE = 8'(STROBE_CYCLES - 1);

  fsm_state_e  phase_q, phase_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        write_q;
  logic        w_write;
  logic        ce_n_q, oe_n_q, we_n_q, dq_oe_q;
  logic [21:0] addr_q;
  logic [15:0] dq_q, rdata_q;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    case (phase_q)
      IDLE:    if (start_i) begin phase_d = SETUP; cnt_d = '0; end
      SETUP:   phase_d = STROBE;
      STROBE:  if (cnt_q == LAST_STROBE) begin phase_d = HOLD; cnt_d = '0; end
               else cnt_d = cnt_q + 8'd1;
      default: phase_d = IDLE;
    endcase
  end

  // Pin outputs are registered from the next phase so they line up with it.
  assign w_write = (phase_q == IDLE) ? write_i : write_q;
  assign done_o  = (phase_q == HOLD);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
      addr_q  <= '0;
      dq_q    <= '0;
      rdata_q <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      if (phase_q == IDLE && start_i) begin
        write_q <= write_i;
        addr_q  <= addr_i;
        dq_q    <= data_i;
      end
      ce_n_q  <= !(phase_d == SETUP || phase_d == STROBE);
      oe_n_q  <= !(phase_d == STROBE && !w_write);
      we_n_q  <= !(phase_d == STROBE && w_write);
      dq_oe_q <= w_write && (phase_d == SETUP || phase_d == STROBE || phase_d == HOLD);
      if (phase_q == STROBE && cnt_q == LAST_STROBE && !write_q) rdata_q <= dq_i;
    end
  end

  assign ce_n_o  = ce_n_q;
  assign oe_n_o  = oe_n_q;
  assign we_n_o  = we_n_q;
  assign dq_oe_o = dq_oe_q;
  assign addr_o  = addr_q;
  assign dq_o    = dq_q;
  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/flash_access_arbiter.sv
// ============================================================================
// Module   : flash_access_arbiter
// Brief    : Round-robin two-requester NOR flash controller (read/program/erase).
//            Define FLASH_ERASE_EN to enable the sector-erase command sequence.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flash_access_arbiter
  import flash_ctrl_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned PROG_WAIT     = 1000
) (
  input  logic             clock_input,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  input  logic [1:0]       req_write,
  input  logic [1:0]       req_erase,
  input  logic [1:0][21:0] req_addr,
  input  logic [1:0][15:0] req_wdata,
  output logic [1:0]       req_done,
  output logic [15:0]      rdata,
  output logic             cmd_err,
  output logic             busy,
  output logic             oFLASH_CE_N,
  output logic             oFLASH_OE_N,
  output logic             oFLASH_WE_N,
  output logic [21:0]      oFLASH_A,
  output logic [15:0]      flash_dq_out,
  output logic             flash_dq_oe,
  input  logic [15:0]      flash_dq_in
);

`ifdef FLASH_ERASE_EN
  localparam bit ERASE_EN = 1'b1;
`else
  localparam bit ERASE_EN = 1'b0;
`endif
  localparam logic [15:0] LAST_WAIT = 16'(PROG_WAIT - 1);

  fsm_state_e  state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [15:0] wait_q, wait_d;
  logic        last_grant_q, gnt_q;
  op_e         op_q;
  logic [21:0] addr_q;
  logic [15:0] wdata_q, rdata_q;
  logic [1:0]  done_q;
  logic        err_q, busy_q;

  logic        w_winner, w_gnt, w_start, w_bus_done;
  op_e         w_req_op, w_op, w_bus_op;
  logic [2:0]  w_bus_step;
  logic [21:0] w_bus_base;
  logic [15:0] w_bus_wdata, w_bus_rdata;

  // Both pending: the requester not granted last wins.
  assign w_winner = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
  assign w_req_op = req_erase[w_winner] ? OP_ERASE :
                    (req_write[w_winner] ? OP_PROG : OP_READ);
  assign w_gnt    = (state_q == IDLE) ? w_winner : gnt_q;
  assign w_op     = (state_q == IDLE) ? w_req_op : op_q;

  // SETUP at this level spans the whole bus cycle run by flash_bus_cycle.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    wait_d      = wait_q;
    w_start     = 1'b0;
    w_bus_op    = op_q;
    w_bus_step  = step_q;
    w_bus_base  = addr_q;
    w_bus_wdata = wdata_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          step_d = 3'd0;
          if (w_req_op == OP_ERASE && !ERASE_EN) begin
            state_d = RESP;
          end else begin
            state_d     = SETUP;
            w_start     = 1'b1;
            w_bus_op    = w_req_op;
            w_bus_step  = 3'd0;
            w_bus_base  = req_addr[w_winner];
            w_bus_wdata = req_wdata[w_winner];
          end
        end
      end
      SETUP: begin
        if (w_bus_done) begin
          if (op_q == OP_READ) begin
            state_d = RESP;
          end else if (step_q == seq_len(op_q) - 3'd1) begin
            state_d = WAIT_DONE;
            wait_d  = '0;
          end else begin
            state_d = NEXT;
            step_d  = step_q + 3'd1;
          end
        end
      end
      NEXT: begin
        state_d = SETUP;
        w_start = 1'b1;
      end
      WAIT_DONE: begin
        if (wait_q == LAST_WAIT) state_d = RESP;
        else wait_d = wait_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_input) begin
    if (reset) begin
      state_q      <= IDLE;
      step_q       <= '0;
      wait_q       <= '0;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      op_q         <= OP_READ;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      done_q       <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      wait_q  <= wait_d;
      if (state_q == IDLE && |req_valid) begin
        last_grant_q <= w_winner;
        gnt_q        <= w_winner;
        op_q         <= w_req_op;
        addr_q       <= req_addr[w_winner];
        wdata_q      <= req_wdata[w_winner];
      end
      done_q <= (state_d == RESP) ? (2'b01 << w_gnt) : 2'b00;
      err_q  <= (state_d == RESP) && (w_op == OP_ERASE) && !ERASE_EN;
      busy_q <= (state_d != IDLE);
      if (state_d == RESP && w_op == OP_READ) rdata_q <= w_bus_rdata;
    end
  end

  flash_bus_cycle #(
    .STROBE_CYCLES(STROBE_CYCLES)
  ) u_bus (
    .clk_i   (clock_input),
    .rst_i   (reset),
    .start_i (w_start),
    .write_i (w_bus_op != OP_READ),
    .addr_i  (seq_addr(w_bus_op, w_bus_step, w_bus_base)),
    .data_i  (seq_data(w_bus_op, w_bus_step, w_bus_wdata)),
    .dq_i    (flash_dq_in),
    .done_o  (w_bus_done),
    .rdata_o (w_bus_rdata),
    .ce_n_o  (oFLASH_CE_N),
    .oe_n_o  (oFLASH_OE_N),
    .we_n_o  (oFLASH_WE_N),
    .addr_o  (oFLASH_A),
    .dq_o    (flash_dq_out),
    .dq_oe_o (flash_dq_oe)
  );

  assign req_done = done_q;
  assign cmd_err  = err_q;
  assign busy     = busy_q;
  assign rdata    = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_flash_access_arbiter.sv
// ============================================================================
// Module   : tb_flash_access_arbiter
// Brief    : Self-checking bench for flash_access_arbiter against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_flash_access_arbiter;

  localparam int S  = 4;
  localparam int PW = 10;
`ifdef FLASH_ERASE_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  typedef struct packed {logic [21:0] a; logic [15:0] d;} bus_wr_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid, req_write, req_erase;
  logic [1:0][21:0] req_addr;
  logic [1:0][15:0] req_wdata;
  logic [1:0]       req_done;
  logic [15:0]      rdata, flash_dq_out, flash_dq_in;
  logic             cmd_err, busy, ce_n, oe_n, we_n, flash_dq_oe;
  logic [21:0]      fa;

  always #5 clk = ~clk;

  flash_access_arbiter #(.STROBE_CYCLES(S), .PROG_WAIT(PW)) dut (
    .clock_input(clk), .reset(rst), .req_valid(req_valid), .req_write(req_write),
    .req_erase(req_erase), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .rdata(rdata), .cmd_err(cmd_err), .busy(busy),
    .oFLASH_CE_N(ce_n), .oFLASH_OE_N(oe_n), .oFLASH_WE_N(we_n), .oFLASH_A(fa),
    .flash_dq_out(flash_dq_out), .flash_dq_oe(flash_dq_oe), .flash_dq_in(flash_dq_in)
  );

  function automatic logic [15:0] flash_word(input logic [21:0] a);
    if (a == 22'h000012) return 16'h00A5;
    return a[15:0] ^ 16'hC3C3 ^ {a[21:16], 10'h000};
  endfunction

  assign flash_dq_in = flash_word(fa);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- bus monitor ----------------
  bus_wr_t     we_q[$];
  int          we_len_q[$];
  logic [21:0] oe_addr_q[$];
  int          oe_len_q[$];
  logic        prev_we = 1'b1, prev_oe = 1'b1, prev_ce = 1'b1, ce_moved = 1'b0;
  int          we_run = 0, oe_run = 0;
  logic [21:0] ce_a = '0;
  logic [15:0] ce_d = '0;

  always @(posedge clk) begin
    #1;
    if (!we_n) begin
      if (prev_we) begin
        we_q.push_back({fa, flash_dq_out});
        check_value("we_drive", {ce_n, flash_dq_oe}, 2'b01);
      end
      we_run++;
    end else if (!prev_we) begin
      we_len_q.push_back(we_run);
      we_run = 0;
    end
    if (!oe_n) begin
      if (prev_oe) begin
        oe_addr_q.push_back(fa);
        check_value("oe_drive", {ce_n, flash_dq_oe}, 2'b00);
      end
      oe_run++;
    end else if (!prev_oe) begin
      oe_len_q.push_back(oe_run);
      oe_run = 0;
    end
    if (!ce_n) begin
      if (prev_ce) begin ce_a = fa; ce_d = flash_dq_out; ce_moved = 1'b0; end
      else if (fa !== ce_a || flash_dq_out !== ce_d) ce_moved = 1'b1;
    end else if (!prev_ce) begin
      check_value("ce_stable", ce_moved, 1'b0);
    end
    prev_we = we_n; prev_oe = oe_n; prev_ce = ce_n;
  end

  // ---------------- reference model ----------------
  int          lg;
  logic [15:0] last_rd;
  int          op_r[2];
  logic [21:0] a_r[2];
  logic [15:0] d_r[2];

  function automatic int n_bus(input int op);
    if (op == 1) return 4;
    if (op == 2) return EN ? 6 : 0;
    return 1;
  endfunction

  function automatic int exp_lat(input int op);
    int n;
    n = n_bus(op);
    if (op == 0) return S + 3;
    if (n == 0) return 1;
    return n * (S + 2) + (n - 1) + PW + 1;
  endfunction

  function automatic bus_wr_t exp_wr(input int op, input int i, input logic [21:0] a,
                                     input logic [15:0] d);
    logic [21:0] pa[6];
    logic [15:0] pd[6];
    pa = '{22'h555, 22'h2AA, 22'h555, 22'h555, 22'h2AA, a};
    if (op == 1) begin
      pd = '{16'hAA, 16'h55, 16'hA0, d, 16'h0, 16'h0};
      return {(i == 3) ? a : pa[i], pd[i]};
    end
    pd = '{16'hAA, 16'h55, 16'h80, 16'hAA, 16'h55, 16'h30};
    return {pa[i], pd[i]};
  endfunction

  task automatic clear_mon();
    we_q.delete(); we_len_q.delete(); oe_addr_q.delete(); oe_len_q.delete();
  endtask

  task automatic issue(input int r, input int op, input logic [21:0] a, input logic [15:0] d);
    op_r[r] = op; a_r[r] = a; d_r[r] = d;
    req_erase[r] = (op == 2);
    req_write[r] = (op == 1) ? 1'b1 : ((op == 2) ? 1'($urandom_range(0, 1)) : 1'b0);
    req_addr[r]  = a;
    req_wdata[r] = d;
    req_valid[r] = 1'b1;
  endtask

  task automatic serve(input int ndone, input bit keep);
    int w, k, op, lat;
    for (int n = 0; n < ndone; n++) begin
      w  = (req_valid == 2'b11) ? 1 - lg : (req_valid[1] ? 1 : 0);
      op = op_r[w];
      k  = 0;
      do begin @(posedge clk); #1; k++; end while (req_done == 2'b00 && k < 2000);
      if (req_done == 2'b00) begin
        check_value("done_timeout", 1'b0, 1'b1);
        req_valid = 2'b00;
        return;
      end
      lat = exp_lat(op) + ((n == 0) ? 0 : 1);
      check_value("done_vec", req_done, 2'b01 << w);
      check_value("latency", k, lat);
      check_value("cmd_err", cmd_err, (op == 2) && !EN);
      check_value("busy_in_resp", busy, 1'b1);
      if (op == 0) begin
        last_rd = flash_word(a_r[w]);
        check_value("rd_pulses", oe_addr_q.size(), 1);
        check_value("rd_addr", (oe_addr_q.size() > 0) ? oe_addr_q[0] : '1, a_r[w]);
        check_value("rd_len", (oe_len_q.size() > 0) ? oe_len_q[0] : 0, S);
        check_value("rd_no_we", we_q.size(), 0);
      end else begin
        check_value("wr_no_oe", oe_addr_q.size(), 0);
        check_value("wr_pulses", we_q.size(), n_bus(op));
        for (int i = 0; i < n_bus(op) && i < we_q.size(); i++) begin
          check_value("wr_cycle", we_q[i], exp_wr(op, i, a_r[w], d_r[w]));
          check_value("wr_len", (i < we_len_q.size()) ? we_len_q[i] : 0, S);
        end
      end
      check_value("rdata", rdata, last_rd);
      clear_mon();
      lg = w;
      if (!keep) req_valid[w] = 1'b0;
    end
    req_valid = 2'b00;
    @(posedge clk); #1;
    check_value("done_pulse_end", req_done, 2'b00);
    check_value("busy_end", busy, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    lg = 1; last_rd = '0;
    clear_mon();
  endtask

  initial begin
    int k, seen, mask, op;
    rst = 1'b1; req_valid = '0; req_write = '0; req_erase = '0; req_addr = '0; req_wdata = '0;
    lg = 1; last_rd = '0;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_strobes", {ce_n, oe_n, we_n}, 3'b111);
    check_value("rst_addr", fa, 22'h0);
    check_value("rst_dq", {flash_dq_out, flash_dq_oe}, 17'h0);
    check_value("rst_outs", {rdata, req_done, cmd_err, busy}, 20'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed read, program and erase
    issue(0, 0, 22'h000012, 16'h0);
    serve(1, 1'b0);
    check_value("rd_a5", rdata, 16'h00A5);
    issue(1, 1, 22'h000040, 16'h003C);
    serve(1, 1'b0);
    issue(0, 2, 22'h010000, 16'h1234);
    serve(1, 1'b0);

    // Continuous contention from reset: alternation starts with requester 0
    do_reset();
    issue(0, 0, 22'h000100, 16'h0);
    issue(1, 0, 22'h000200, 16'h0);
    serve(4, 1'b1);
    check_value("contend_last", lg, 1);

    // Reset during the third program bus cycle
    issue(1, 1, 22'h000040, 16'h003C);
    k = 0;
    while (we_q.size() < 3 && k < 200) begin @(posedge clk); #1; k++; end
    check_value("third_cycle_reached", we_q.size() >= 3, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_value("abort_strobes", {ce_n, oe_n, we_n, flash_dq_oe}, 4'b1110);
    check_value("abort_busy", {busy, req_done}, 3'b000);
    rst = 1'b0; req_valid = 2'b00; lg = 1; last_rd = '0;
    seen = 0;
    repeat (60) begin @(posedge clk); #1; if (req_done != 2'b00 || !we_n) seen++; end
    check_value("abort_quiet", seen, 0);
    clear_mon();

    // Randomized single and paired requests
    for (int it = 0; it < 40; it++) begin
      mask = $urandom_range(1, 3);
      for (int r = 0; r < 2; r++) begin
        if (mask[r]) begin
          k  = $urandom_range(0, 9);
          op = (k < 5) ? 0 : ((k < 8) ? 1 : 2);
          issue(r, op, 22'($urandom), 16'($urandom));
        end
      end
      serve((mask == 3) ? 2 : 1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/flash_access_arbiter.md
FLASH_ACCESS_ARBITER -- requirements
Module: flash_access_arbiter

Interface
REQ-001 SHALL have parameter STROBE_CYCLES, default 4: clock_input cycles WE_N/OE_N held low per bus cycle (range 1..255).
REQ-002 SHALL have parameter PROG_WAIT, default 1000: clock_input cycles idle after the final program/erase bus cycle (range 1..65535).
REQ-003 SHALL have port clock_input, input, 1: single clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 2: per-requester request, held high until its done pulse.
REQ-006 SHALL have port req_write, input, 2: per-requester 1 = program, 0 = read.
REQ-007 SHALL have port req_erase, input, 2: per-requester sector erase; overrides req_write.
REQ-008 SHALL have port req_addr, input, 2x22: per-requester word address.
REQ-009 SHALL have port req_wdata, input, 2x16: per-requester program data.
REQ-010 SHALL have port req_done, output, 2: one-cycle completion pulse to the granted requester.
REQ-011 SHALL have port rdata, output, 16: read data, valid in the req_done cycle and held until the next read completes.
REQ-012 SHALL have port cmd_err, output, 1: one-cycle pulse alongside req_done for a rejected command.
REQ-013 SHALL have port busy, output, 1: high from grant through req_done.
REQ-014 SHALL have ports oFLASH_CE_N, oFLASH_OE_N, oFLASH_WE_N (outputs, 1 each), oFLASH_A (output, 22), flash_dq_out (output, 16), flash_dq_oe (output, 1), flash_dq_in (input, 16).

Function
REQ-015 SHALL have FSM states IDLE, SETUP, STROBE, HOLD, NEXT, WAIT_DONE, RESP.
REQ-016 IDLE with any req_valid SHALL grant one requester, latch its op/addr/wdata, go to SETUP; requests are evaluated only in IDLE.
REQ-017 Arbitration SHALL be round-robin: single request wins; if both are valid, the requester not granted last wins; last_grant resets to 1, so requester 0 wins first.
REQ-018 SETUP (1 cycle) SHALL drive CE_N=0 with address/data; on writes flash_dq_oe=1.
REQ-019 STROBE (STROBE_CYCLES) SHALL drive WE_N=0 (write) or OE_N=0 (read); a read SHALL capture flash_dq_in on the last STROBE cycle.
REQ-020 HOLD (1 cycle) SHALL drive WE_N=OE_N=CE_N=1 with address/data unchanged; flash_dq_oe SHALL drop in the cycle after HOLD.
REQ-021 Read SHALL be one bus cycle, with req_done exactly STROBE_CYCLES+3 cycles after the grant edge.
REQ-022 Program SHALL issue four bus cycles: 0x555/0xAA, 0x2AA/0x55, 0x555/0xA0, then addr/wdata, with one NEXT cycle between bus cycles, then WAIT_DONE for PROG_WAIT cycles, then RESP.
REQ-023 RESP (1 cycle) SHALL pulse req_done for the granted requester, then return to IDLE, so back-to-back requests lose one cycle.
REQ-024 Address and data SHALL never change while CE_N=0.
REQ-025 Requests dropped mid-transaction SHALL be ignored; the transaction SHALL complete.

Reset
REQ-026 Reset SHALL put the FSM in IDLE with CE_N=OE_N=WE_N=1, oFLASH_A=0, flash_dq_out=0, flash_dq_oe=0, rdata=0, req_done=0, cmd_err=0, busy=0 and all counters at 0.
REQ-027 Reset mid-transaction SHALL abort on the next edge with no further strobes and no req_done.

Configuration
REQ-028 With FLASH_ERASE_EN defined, req_erase SHALL issue six bus cycles: 0x555/0xAA, 0x2AA/0x55, 0x555/0x80, 0x555/0xAA, 0x2AA/0x55, addr/0x30, followed by WAIT_DONE for PROG_WAIT cycles.
REQ-029 Without FLASH_ERASE_EN, an erase request SHALL issue no bus cycle and SHALL pulse req_done and cmd_err together one cycle after the grant.

Structure
REQ-030 Package flash_ctrl_pkg SHALL hold the state enum, the unlock addresses 0x555/0x2AA and the data codes 0xAA/0x55/0xA0/0x80/0x30.
REQ-031 Sub-module flash_bus_cycle SHALL execute one SETUP/STROBE/HOLD cycle on a start pulse and return a done pulse.

Verification (STROBE_CYCLES=4, PROG_WAIT=10)
REQ-032 Read: requester 0 reads addr 0x000012, model returns 0x00A5 -> OE_N low 4 cycles, req_done[0] 7 cycles after grant, rdata=0x00A5.
REQ-033 Program: requester 1 writes 0x3C at 0x000040 -> WE_N pulses carry 555/AA, 2AA/55, 555/A0, 040/3C, in order, then req_done[1] 10 cycles after the last HOLD.
REQ-034 Contention: both requesters request reads continuously -> grants alternate 0,1,0,1; neither is starved.
REQ-035 Reset: assert reset during the third program bus cycle -> all strobes high and flash_dq_oe=0 on the next edge, no req_done.
REQ-036 Erase at 0x010000: with FLASH_ERASE_EN -> six bus cycles ending 010000/30; without it -> no bus activity, req_done and cmd_err one cycle after the grant.
